wash_run: RTL and testbench

//  Run-stage controller directly downstream of the balance/mode/weight entry stage.

---
 rtl/wash_run_if.sv | 31 +++
 rtl/wash_run.sv | 261 ++++++++++++++++++++++++++
 tb/tb_wash_run.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wash_run_if.sv
// ---------------------------------------------------------------------------
// wash_run_if
// Bundle between the balance/mode/weight entry stage (master) and the
// wash_run run-stage controller (slave).
//   master drives : start, mode, weight, bal_in, pause, abort
//   slave drives  : busy, phase, remain_s, bal_out, err, done
// ---------------------------------------------------------------------------
interface wash_run_if;
   logic               start;     // 1-cycle request pulse
   logic        [1:0]  mode;      // 00 spin-only, 01 small, 10 medium, 11 large
   logic        [4:0]  weight;    // load in kg
   logic signed [11:0] bal_in;    // balance entered upstream
   logic               pause;     // level, lid open
   logic               abort;     // 1-cycle cancel pulse
   logic               busy;      // CHECK through SPIN
   logic        [2:0]  phase;     // one-hot [0] wash [1] rinse [2] spin
   logic        [9:0]  remain_s;  // seconds left over all remaining phases
   logic signed [11:0] bal_out;   // balance after charge
   logic               err;       // request rejected
   logic               done;      // 1-cycle pulse at end of SPIN

   modport master (
      output start, mode, weight, bal_in, pause, abort,
      input  busy, phase, remain_s, bal_out, err, done
   );

   modport slave (
      input  start, mode, weight, bal_in, pause, abort,
      output busy, phase, remain_s, bal_out, err, done
   );
endinterface

// File: rtl/wash_run.sv
// ---------------------------------------------------------------------------
// wash_run
// Run-stage controller of the washing machine. Takes a start request with
// mode, load weight and balance, charges the wash cost, then sequences
// WASH -> RINSE -> SPIN on 1 s ticks derived from the system clock.
//
// Ports
//   clk   in  system clock
//   rst   in  asynchronous reset, active-high
//   bus   wash_run_if.slave
//         in : start, mode, weight, bal_in, pause, abort
//         out: busy, phase, remain_s, bal_out, err, done
// ---------------------------------------------------------------------------
module wash_run #(
   parameter int TICK_DIV = 100_000_000,  // clk cycles per 1 s tick
   parameter int PRICE_KG = 2,            // cost per kg
   parameter int BASE     = 5,            // cost per mode step
   parameter int WASH_S   = 10,           // wash seconds per mode step
   parameter int RINSE_S  = 8,            // rinse seconds (modes 01..11)
   parameter int SPIN_S   = 6,            // spin seconds (all modes)
   parameter int ERR_S    = 3             // seconds err is held
) (
   input logic       clk,
   input logic       rst,
   wash_run_if.slave bus
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_WASH,
      S_RINSE,
      S_SPIN,
      S_ERR
   } state_t;

   // ------------------------------------------------------------------
   // Helper functions
   // ------------------------------------------------------------------
   function automatic logic [4:0] limit_f(input logic [1:0] m);
      case (m)
         2'b01:   return 5'd9;
         2'b10:   return 5'd19;
         default: return 5'd29;   // 00 and 11 share the large-drum limit
      endcase
   endfunction

   function automatic logic [11:0] cost_f(input logic [1:0] m, input logic [4:0] w);
      return 12'(PRICE_KG * int'(w) + BASE * int'(m));
   endfunction

   function automatic logic [9:0] wash_s_f(input logic [1:0] m);
      return 10'(WASH_S * int'(m));
   endfunction

   // ------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------
   state_t             state_q;
   logic [TW-1:0]      tick_q;
   logic [9:0]         sec_q;      // seconds left in the current phase / ERR hold
   logic [9:0]         remain_q;
   logic [2:0]         phase_q;
   logic               busy_q;
   logic signed [11:0] bal_out_q;
   logic               err_q;
   logic               done_q;

   // Request latched in IDLE, evaluated in CHECK
   logic        [1:0]  mode_q;
   logic        [4:0]  wt_q;
   logic signed [11:0] bal_q;

   // ------------------------------------------------------------------
   // CHECK evaluation (combinational on latched request)
   // ------------------------------------------------------------------
   logic [11:0] cost_d;
   logic [4:0]  lim_d;
   logic        reject_d;
   logic [9:0]  wash_d;
   logic [9:0]  run_rem_d;

   always_comb begin
      cost_d    = cost_f(mode_q, wt_q);
      lim_d     = limit_f(mode_q);
      wash_d    = wash_s_f(mode_q);
      // Negative balance is rejected first, so the cost compare can be unsigned.
      reject_d  = (wt_q > lim_d) || bal_q[11] || ($unsigned(bal_q) < cost_d);
      run_rem_d = (mode_q == 2'b00) ? 10'(SPIN_S)
                                    : wash_d + 10'(RINSE_S) + 10'(SPIN_S);
   end

   // ------------------------------------------------------------------
   // Phase advance targets (what the next phase looks like on exit)
   // ------------------------------------------------------------------
   state_t     adv_state_d;
   logic [2:0] adv_phase_d;
   logic [9:0] adv_sec_d;
   logic       adv_busy_d;
   logic       adv_done_d;

   always_comb begin
      adv_state_d = S_IDLE;
      adv_phase_d = 3'b000;
      adv_sec_d   = '0;
      adv_busy_d  = 1'b0;
      adv_done_d  = 1'b0;
      case (state_q)
         S_WASH: begin
            adv_state_d = S_RINSE;
            adv_phase_d = 3'b010;
            adv_sec_d   = 10'(RINSE_S);
            adv_busy_d  = 1'b1;
         end
         S_RINSE: begin
            adv_state_d = S_SPIN;
            adv_phase_d = 3'b100;
            adv_sec_d   = 10'(SPIN_S);
            adv_busy_d  = 1'b1;
         end
         S_SPIN: begin
            adv_done_d  = 1'b1;
         end
         default: ;
      endcase
   end

   logic tick_wrap_d;
   assign tick_wrap_d = (tick_q == TW'(TICK_DIV - 1));

   // ------------------------------------------------------------------
   // Request capture (data only, no reset needed)
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && bus.start) begin
         mode_q <= bus.mode;
         wt_q   <= bus.weight;
         bal_q  <= bus.bal_in;
      end
   end

   // ------------------------------------------------------------------
   // Main FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         tick_q    <= '0;
         sec_q     <= '0;
         remain_q  <= '0;
         phase_q   <= 3'b000;
         busy_q    <= 1'b0;
         bal_out_q <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // abort is meaningless here, so start always wins
               if (bus.start) begin
                  state_q <= S_CHECK;
                  busy_q  <= 1'b1;
               end
            end

            S_CHECK: begin
               tick_q <= '0;
               if (reject_d) begin
                  state_q <= S_ERR;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
                  sec_q   <= 10'(ERR_S);
               end else begin
                  bal_out_q <= bal_q - $signed(cost_d);
                  remain_q  <= run_rem_d;
                  if (mode_q == 2'b00) begin
                     state_q <= S_SPIN;
                     phase_q <= 3'b100;
                     sec_q   <= 10'(SPIN_S);
                  end else begin
                     state_q <= S_WASH;
                     phase_q <= 3'b001;
                     sec_q   <= wash_d;
                  end
               end
            end

            S_WASH, S_RINSE, S_SPIN: begin
               if (bus.abort) begin
                  // Cancel without refund: bal_out keeps its charged value.
                  state_q  <= S_IDLE;
                  busy_q   <= 1'b0;
                  phase_q  <= 3'b000;
                  remain_q <= '0;
                  sec_q    <= '0;
                  tick_q   <= '0;
               end else if (sec_q == '0) begin
                  // Zero-length phase: pass through in a single cycle.
                  state_q <= adv_state_d;
                  phase_q <= adv_phase_d;
                  sec_q   <= adv_sec_d;
                  busy_q  <= adv_busy_d;
                  done_q  <= adv_done_d;
                  tick_q  <= '0;
               end else if (!bus.pause) begin
                  if (tick_wrap_d) begin
                     tick_q   <= '0;
                     remain_q <= remain_q - 10'd1;
                     sec_q    <= sec_q - 10'd1;
                     if (sec_q == 10'd1) begin
                        state_q <= adv_state_d;
                        phase_q <= adv_phase_d;
                        sec_q   <= adv_sec_d;
                        busy_q  <= adv_busy_d;
                        done_q  <= adv_done_d;
                     end
                  end else begin
                     tick_q <= tick_q + TW'(1);
                  end
               end
            end

            S_ERR: begin
               if (tick_wrap_d) begin
                  tick_q <= '0;
                  if (sec_q <= 10'd1) begin
                     state_q <= S_IDLE;
                     err_q   <= 1'b0;
                     sec_q   <= '0;
                  end else begin
                     sec_q <= sec_q - 10'd1;
                  end
               end else begin
                  tick_q <= tick_q + TW'(1);
               end
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               phase_q <= 3'b000;
               err_q   <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.busy     = busy_q;
   assign bus.phase    = phase_q;
   assign bus.remain_s = remain_q;
   assign bus.bal_out  = bal_out_q;
   assign bus.err      = err_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_wash_run.sv
// ---------------------------------------------------------------------------
// tb_wash_run
// Scoreboard bench for wash_run with TICK_DIV=4. Stimulus pushes the
// expected output events (absolute cycle + full output snapshot) into a
// queue; a monitor pops and compares whenever busy/phase/err/done change.
// ---------------------------------------------------------------------------
module tb_wash_run;

   logic clk;
   logic rst;
   int   cyc;
   int   n_vec;
   int   n_bad;
   logic mon_en;

   wash_run_if bus();

   wash_run #(.TICK_DIV(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int                 c;
      logic               busy;
      logic        [2:0]  ph;
      logic        [9:0]  rem;
      logic signed [11:0] bal;
      logic               err;
      logic               done;
   } ev_t;

   ev_t exp_q[$];
   ev_t me;
   logic [5:0] mon_prev;
   logic [5:0] mon_cur;

   task automatic push(input int c, input logic b, input logic [2:0] p,
                       input int r, input int bl, input logic e, input logic d);
      ev_t x;
      x.c = c; x.busy = b; x.ph = p; x.rem = 10'(r); x.bal = 12'(bl);
      x.err = e; x.done = d;
      exp_q.push_back(x);
   endtask

   // Monitor: one comparison per output event
   always @(negedge clk) begin
      if (mon_en) begin
         mon_cur = {bus.busy, bus.phase, bus.err, bus.done};
         if (mon_cur != mon_prev) begin
            mon_prev = mon_cur;
            n_vec++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_event cyc=%0d got busy=%b phase=%b rem=%0d bal=%0d err=%b done=%b required no event",
                        cyc, bus.busy, bus.phase, bus.remain_s, bus.bal_out, bus.err, bus.done);
            end else begin
               me = exp_q.pop_front();
               if (me.c != cyc || me.busy != bus.busy || me.ph != bus.phase ||
                   me.rem != bus.remain_s || me.bal != bus.bal_out ||
                   me.err != bus.err || me.done != bus.done) begin
                  n_bad++;
                  $display("FAIL event got cyc=%0d busy=%b phase=%b rem=%0d bal=%0d err=%b done=%b required cyc=%0d busy=%b phase=%b rem=%0d bal=%0d err=%b done=%b",
                           cyc, bus.busy, bus.phase, bus.remain_s, bus.bal_out, bus.err, bus.done,
                           me.c, me.busy, me.ph, me.rem, me.bal, me.err, me.done);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s got=%0d required=%0d", name, got, want);
      end
   endtask

   task automatic sync(output int k);
      @(negedge clk);
      k = cyc;
   endtask

   task automatic go(input logic [1:0] m, input logic [4:0] w,
                     input int b, input logic ab);
      bus.mode   = m;
      bus.weight = w;
      bus.bal_in = 12'(b);
      bus.start  = 1'b1;
      bus.abort  = ab;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.abort  = 1'b0;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"},  int'(bus.busy),     0);
      chk({tag, "_phase"}, int'(bus.phase),    0);
      chk({tag, "_rem"},   int'(bus.remain_s), 0);
      chk({tag, "_bal"},   int'(bus.bal_out),  0);
      chk({tag, "_err"},   int'(bus.err),      0);
      chk({tag, "_done"},  int'(bus.done),     0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d required completion", cyc);
      $fatal(1, "time limit reached");
   end

   initial begin
      int k;
      cyc = 0; n_vec = 0; n_bad = 0; mon_en = 1'b0; mon_prev = '0;
      rst = 1'b1;
      bus.start = 1'b0; bus.mode = 2'b00; bus.weight = '0; bus.bal_in = '0;
      bus.pause = 1'b0; bus.abort = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;

      // 1: small load, full run, 24 s
      sync(k);
      push(k+1,  1, 3'b000,  0,  0, 0, 0);
      push(k+2,  1, 3'b001, 24, 35, 0, 0);
      push(k+42, 1, 3'b010, 14, 35, 0, 0);
      push(k+74, 1, 3'b100,  6, 35, 0, 0);
      push(k+98, 0, 3'b000,  0, 35, 0, 1);
      push(k+99, 0, 3'b000,  0, 35, 0, 0);
      go(2'b01, 5'd5, 50, 1'b0);
      wait_until(k+105);

      // 2: spin-only, balance exactly equal to cost
      sync(k);
      push(k+1,  1, 3'b000, 0, 35, 0, 0);
      push(k+2,  1, 3'b100, 6,  0, 0, 0);
      push(k+26, 0, 3'b000, 0,  0, 0, 1);
      push(k+27, 0, 3'b000, 0,  0, 0, 0);
      go(2'b00, 5'd20, 40, 1'b0);
      wait_until(k+32);

      // 3a: overweight; 3b: insufficient balance; 3c: negative balance
      sync(k);
      push(k+1,  1, 3'b000, 0, 0, 0, 0);
      push(k+2,  0, 3'b000, 0, 0, 1, 0);
      push(k+14, 0, 3'b000, 0, 0, 0, 0);
      go(2'b01, 5'd12, 99, 1'b0);
      wait_until(k+18);

      sync(k);
      push(k+1,  1, 3'b000, 0, 0, 0, 0);
      push(k+2,  0, 3'b000, 0, 0, 1, 0);
      push(k+14, 0, 3'b000, 0, 0, 0, 0);
      go(2'b11, 5'd10, 20, 1'b0);
      wait_until(k+18);

      sync(k);
      push(k+1,  1, 3'b000, 0, 0, 0, 0);
      push(k+2,  0, 3'b000, 0, 0, 1, 0);
      push(k+14, 0, 3'b000, 0, 0, 0, 0);
      go(2'b01, 5'd1, -5, 1'b0);
      wait_until(k+18);

      // 4: medium load, 40-cycle pause mid-WASH
      sync(k);
      push(k+1,   1, 3'b000,  0,  0, 0, 0);
      push(k+2,   1, 3'b001, 34, 84, 0, 0);
      push(k+122, 1, 3'b010, 14, 84, 0, 0);
      push(k+154, 1, 3'b100,  6, 84, 0, 0);
      push(k+178, 0, 3'b000,  0, 84, 0, 1);
      push(k+179, 0, 3'b000,  0, 84, 0, 0);
      go(2'b10, 5'd3, 100, 1'b0);
      wait_until(k+20);
      chk("pause_rem_before", int'(bus.remain_s), 30);
      bus.pause = 1'b1;
      wait_until(k+40);
      chk("pause_rem_mid",   int'(bus.remain_s), 30);
      chk("pause_phase_mid", int'(bus.phase),    1);
      chk("pause_busy_mid",  int'(bus.busy),     1);
      wait_until(k+60);
      chk("pause_rem_after", int'(bus.remain_s), 30);
      bus.pause = 1'b0;
      wait_until(k+185);

      // 5: weight at limit, stray starts ignored, abort during RINSE
      sync(k);
      push(k+1,  1, 3'b000,  0, 84, 0, 0);
      push(k+2,  1, 3'b001, 24,  7, 0, 0);
      push(k+42, 1, 3'b010, 14,  7, 0, 0);
      push(k+51, 0, 3'b000,  0,  7, 0, 0);
      go(2'b01, 5'd9, 30, 1'b0);
      wait_until(k+20);
      go(2'b00, 5'd0, 100, 1'b0);
      wait_until(k+45);
      go(2'b00, 5'd0, 100, 1'b0);
      wait_until(k+50);
      chk("abort_rem_before", int'(bus.remain_s), 12);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      wait_until(k+120);

      // 6: reset mid-SPIN, then start+abort together in IDLE
      sync(k);
      push(k+1,  1, 3'b000, 0,  7, 0, 0);
      push(k+2,  1, 3'b100, 6, 10, 0, 0);
      push(k+11, 0, 3'b000, 0,  0, 0, 0);
      go(2'b00, 5'd0, 10, 1'b0);
      wait_until(k+10);
      #1 rst = 1'b1;
      #1 chk_zero("midrst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      sync(k);
      push(k+1,  1, 3'b000,  0,  0, 0, 0);
      push(k+2,  1, 3'b001, 24, 15, 0, 0);
      push(k+42, 1, 3'b010, 14, 15, 0, 0);
      push(k+74, 1, 3'b100,  6, 15, 0, 0);
      push(k+98, 0, 3'b000,  0, 15, 0, 1);
      push(k+99, 0, 3'b000,  0, 15, 0, 0);
      go(2'b01, 5'd0, 20, 1'b1);
      wait_until(k+110);

      while (exp_q.size() > 0) begin
         me = exp_q.pop_front();
         n_vec++;
         n_bad++;
         $display("FAIL missing_event got none required cyc=%0d busy=%b phase=%b rem=%0d bal=%0d err=%b done=%b",
                  me.c, me.busy, me.ph, me.rem, me.bal, me.err, me.done);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
